// File: rtl/ram_rw_s_arbiter.sv
// Two-port (A/B) arbiter in front of a single-port RAM with asynchronous read.
// Round-robin grants with an optional lock that is capped at MAX_BURST cycles.
module ram_rw_s_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  b_req,
    input  logic                  a_wr,
    input  logic                  b_wr,
    input  logic                  a_lock,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  a_err,
    output logic                  b_err,
    output logic                  ram_cs_n,
    output logic                  ram_wr_n,
    output logic [ADDR_WIDTH-1:0] ram_rw_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [3:0]            MAX_BURST_C = 4'(MAX_BURST);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C     = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state_q;
    logic                  rr_q;
    logic [3:0]            bcnt_q;
    logic                  a_rvalid_q, b_rvalid_q;
    logic                  a_err_q, b_err_q;
    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

    logic                  gnt_a, gnt_b;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  in_range;
    logic                  ram_cs;

    // Grant selection; reset forces both grants low so nothing reaches the RAM
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end else begin
            case (state_q)
                OWN_A: begin
                    if (a_req) begin
                        if (!b_req || (a_lock && (bcnt_q < MAX_BURST_C))) gnt_a = 1'b1;
                        else                                             gnt_b = 1'b1;
                    end else begin
                        gnt_b = b_req;
                    end
                end
                OWN_B: begin
                    if (b_req) begin
                        if (!a_req || (b_lock && (bcnt_q < MAX_BURST_C))) gnt_b = 1'b1;
                        else                                             gnt_a = 1'b1;
                    end else begin
                        gnt_a = a_req;
                    end
                end
                default: begin
                    if (a_req && b_req) begin
                        gnt_a = ~rr_q;
                        gnt_b = rr_q;
                    end else begin
                        gnt_a = a_req;
                        gnt_b = b_req;
                    end
                end
            endcase
        end
    end

    assign sel_wr    = gnt_b ? b_wr    : a_wr;
    assign sel_addr  = gnt_b ? b_addr  : a_addr;
    assign sel_wdata = gnt_b ? b_wdata : a_wdata;
    assign in_range  = ({1'b0, sel_addr} < DEPTH_C);
    assign ram_cs    = (gnt_a | gnt_b) & in_range;

    assign ram_cs_n    = ~ram_cs;
    assign ram_wr_n    = ~(ram_cs & sel_wr);
    assign ram_rw_addr = ram_cs ? sel_addr  : {ADDR_WIDTH{1'b0}};
    assign ram_data_in = ram_cs ? sel_wdata : {DATA_WIDTH{1'b0}};

    // Ownership FSM, burst counter, round-robin pointer and read/error return path
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            bcnt_q     <= 4'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            a_rdata_q  <= {DATA_WIDTH{1'b0}};
            b_rdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            a_rvalid_q <= gnt_a & ram_cs & ~sel_wr;
            b_rvalid_q <= gnt_b & ram_cs & ~sel_wr;
            a_err_q    <= gnt_a & ~in_range;
            b_err_q    <= gnt_b & ~in_range;
            if (gnt_a && ram_cs && !sel_wr) a_rdata_q <= ram_data_out;
            else                            a_rdata_q <= a_rdata_q;
            if (gnt_b && ram_cs && !sel_wr) b_rdata_q <= ram_data_out;
            else                            b_rdata_q <= b_rdata_q;
            if (gnt_a) begin
                state_q <= OWN_A;
                rr_q    <= 1'b1;
                if (state_q == OWN_A) bcnt_q <= (bcnt_q == 4'd15) ? 4'd15 : bcnt_q + 4'd1;
                else                  bcnt_q <= 4'd1;
            end else if (gnt_b) begin
                state_q <= OWN_B;
                rr_q    <= 1'b0;
                if (state_q == OWN_B) bcnt_q <= (bcnt_q == 4'd15) ? 4'd15 : bcnt_q + 4'd1;
                else                  bcnt_q <= 4'd1;
            end else begin
                state_q <= IDLE;
                rr_q    <= rr_q;
                bcnt_q  <= 4'd0;
            end
        end
    end

    // Reset also masks the registered outputs during the reset cycle itself
    assign a_gnt    = gnt_a;
    assign b_gnt    = gnt_b;
    assign a_rvalid = a_rvalid_q & ~rst;
    assign b_rvalid = b_rvalid_q & ~rst;
    assign a_err    = a_err_q & ~rst;
    assign b_err    = b_err_q & ~rst;
    assign a_rdata  = rst ? {DATA_WIDTH{1'b0}} : a_rdata_q;
    assign b_rdata  = rst ? {DATA_WIDTH{1'b0}} : b_rdata_q;
    assign busy     = (state_q != IDLE) & ~rst;

endmodule

// File: tb/tb_ram_rw_s_arbiter.sv
// Directed + random bench for ram_rw_s_arbiter against a transaction-level model
// (owner / streak / preference plus a word array standing in for the RAM).
module tb_ram_rw_s_arbiter;
    localparam int DW = 8, DEPTH = 6, AW = 3, MAXB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, a_req, b_req, a_wr, b_wr, a_lock, b_lock;
    logic [AW-1:0] a_addr, b_addr, ram_rw_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_data_in, ram_data_out;
    logic a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, ram_cs_n, ram_wr_n, busy;

    ram_rw_s_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_wr(a_wr), .b_wr(b_wr),
        .a_lock(a_lock), .b_lock(b_lock), .a_addr(a_addr), .b_addr(b_addr),
        .a_wdata(a_wdata), .b_wdata(b_wdata), .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .a_err(a_err), .b_err(b_err), .ram_cs_n(ram_cs_n), .ram_wr_n(ram_wr_n),
        .ram_rw_addr(ram_rw_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .busy(busy));

    // Simple RAM with asynchronous read
    logic [DW-1:0] ram [0:7];
    assign ram_data_out = ram[ram_rw_addr];
    always @(posedge clk) if (!ram_cs_n && !ram_wr_n) ram[ram_rw_addr] <= ram_data_in;

    // Reference model state: owner 0=none 1=A 2=B, pref 0=A first 1=B first
    int m_owner = 0, m_streak = 0, m_pref = 0;
    logic m_rv_a = 1'b0, m_rv_b = 1'b0, m_err_a = 1'b0, m_err_b = 1'b0;
    logic [DW-1:0] m_rd_a = '0, m_rd_b = '0;
    logic [DW-1:0] m_mem [0:7];
    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic ar, input logic awr, input logic alk,
                       input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                       input logic br, input logic bwr, input logic blk,
                       input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
        int g;
        logic wr;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        bit hit;
        rst = r; a_req = ar; a_wr = awr; a_lock = alk; a_addr = aad; a_wdata = awd;
        b_req = br; b_wr = bwr; b_lock = blk; b_addr = bad; b_wdata = bwd;
        #2;
        // Who should own the RAM this cycle
        g = 0;
        if (!r) begin
            if (m_owner == 1 && ar)      g = (!br || (alk && m_streak < MAXB)) ? 1 : 2;
            else if (m_owner == 2 && br) g = (!ar || (blk && m_streak < MAXB)) ? 2 : 1;
            else if (ar && br)           g = (m_owner == 1) ? 2 : (m_owner == 2) ? 1 : (m_pref + 1);
            else if (ar)                 g = 1;
            else if (br)                 g = 2;
        end
        wr = (g == 2) ? bwr : awr;
        ad = (g == 2) ? bad : aad;
        wd = (g == 2) ? bwd : awd;
        hit = (g != 0) && (int'(ad) < DEPTH);
        chk("a_gnt", a_gnt, g == 1);
        chk("b_gnt", b_gnt, g == 2);
        chk("ram_cs_n", ram_cs_n, !hit);
        chk("ram_wr_n", ram_wr_n, !(hit && wr));
        chk("ram_rw_addr", ram_rw_addr, hit ? ad : '0);
        chk("ram_data_in", ram_data_in, hit ? wd : '0);
        chk("busy", busy, (m_owner != 0) && !r);
        chk("a_rvalid", a_rvalid, m_rv_a && !r);
        chk("b_rvalid", b_rvalid, m_rv_b && !r);
        chk("a_err", a_err, m_err_a && !r);
        chk("b_err", b_err, m_err_b && !r);
        chk("a_rdata", a_rdata, r ? '0 : m_rd_a);
        chk("b_rdata", b_rdata, r ? '0 : m_rd_b);
        // Advance the model to the next cycle
        m_rv_a = 1'b0; m_rv_b = 1'b0; m_err_a = 1'b0; m_err_b = 1'b0;
        if (r) begin
            m_owner = 0; m_streak = 0; m_pref = 0; m_rd_a = '0; m_rd_b = '0;
        end else if (g == 0) begin
            m_owner = 0; m_streak = 0;
        end else begin
            m_streak = (m_owner == g) ? ((m_streak == 15) ? 15 : m_streak + 1) : 1;
            m_owner = g;
            m_pref = (g == 1) ? 1 : 0;
            if (!hit) begin
                if (g == 1) m_err_a = 1'b1; else m_err_b = 1'b1;
            end else if (wr) begin
                m_mem[ad] = wd;
            end else if (g == 1) begin
                m_rv_a = 1'b1; m_rd_a = m_mem[ad];
            end else begin
                m_rv_b = 1'b1; m_rd_b = m_mem[ad];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and idle
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        // Fill every in-range word
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, AW'(i), DW'($urandom), 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        // Write then read back next cycle
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        // Contention without lock right after reset
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 1'b0, AW'(i % DEPTH), 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        // Lock capped at MAX_BURST
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b1, AW'(i % DEPTH), 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        // Out-of-range read by B
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        // Reset right after a granted read
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        // Refill after the reset, then random traffic
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, AW'(i), DW'($urandom));
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 7)), DW'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 7)), DW'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
